router_fifo: RTL and testbench

- Per-port output FIFO of the 1x3 router, directly downstream of router_sync; three instances, one per destination port.
- Stores bytes when router_sync's one-hot write_enb selects it, and drives data_out to the port reader on read_enb.
- Tracks packet boundaries with a header tag so the reader sees a clean idle value between packets.
- Supports router_sync's per-port soft_reset, which flushes a packet left unread too long.

---
 rtl/router_fifo_if.sv | 36 +++
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Byte-stream interface between the router write side, one output FIFO
// and its port reader. Optional err flag present with FIFO_ERR_FLAG_EN.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef FIFO_ERR_FLAG_EN
    logic             err;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, err
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, err
    );
`else
    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
`endif
endinterface

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router. Each entry carries a header tag
// so a packet byte counter can return data_out to zero between packets.
// soft_reset flushes the FIFO exactly like reset.
// Optional sticky illegal-access flag err is enabled by FIFO_ERR_FLAG_EN.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            soft_reset,
    router_fifo_if.slave    bus
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [5:0]       pkt_cnt;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH:0]   rd_word;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             flush;

    // Flags come straight from the registered pointers
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        flush   = reset || soft_reset;
        do_push = bus.write_enb && !full && !flush;
        do_pop  = bus.read_enb && !empty && !flush;
        rd_word = mem[rd_ptr[ADDR_W-1:0]];
    end

    // Storage array; contents are never cleared, only the pointers are
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // Pointers, packet byte counter and registered read data
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            data_out_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                data_out_q <= rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    pkt_cnt <= rd_word[WIDTH-1 -: 6] + 6'd1;
                end else if (pkt_cnt != 6'd0) begin
                    pkt_cnt <= pkt_cnt - 6'd1;
                end
            end else if (pkt_cnt == 6'd0) begin
                data_out_q <= '0;
            end
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic err_q;

    // Sticky flag for a push while full or a pop while empty
    always_ff @(posedge clock) begin
        if (flush) begin
            err_q <= 1'b0;
        end else if ((bus.write_enb && full) || (bus.read_enb && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed steps from the test plan
// followed by randomized traffic, all compared against a queue-based model.
// Build with FIFO_ERR_FLAG_EN defined to also check the err flag.
module tb_router_fifo;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of {tag, byte} plus the expected outputs
    logic [8:0] m_q[$];
    logic [7:0] m_dout;
    logic [5:0] m_cnt;
    logic       m_err;
    int         checks = 0;
    int         errors = 0;

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic applyStimulus(input logic rst, input logic sr, input logic we,
                                 input logic re, input logic lfd, input logic [7:0] din);
        logic       was_full;
        logic       was_empty;
        logic [8:0] w;
        reset         = rst;
        soft_reset    = sr;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        @(posedge clock);
        was_full  = (m_q.size() == 16);
        was_empty = (m_q.size() == 0);
        if (rst || sr) begin
            m_q.delete();
            m_dout = 8'h00;
            m_cnt  = 6'd0;
            m_err  = 1'b0;
        end else begin
            if ((we && was_full) || (re && was_empty)) m_err = 1'b1;
            if (re && !was_empty) begin
                w      = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = w[7:2] + 6'd1;
                else if (m_cnt != 6'd0) m_cnt = m_cnt - 6'd1;
            end else if (m_cnt == 6'd0) begin
                m_dout = 8'h00;
            end
            if (we && !was_full) m_q.push_back({lfd, din});
        end
        #1;
        checkOutput();
    endtask

    // Compare DUT outputs against the model
    task automatic checkOutput();
        logic exp_full;
        logic exp_empty;
        exp_full  = (m_q.size() == 16);
        exp_empty = (m_q.size() == 0);
        checks++;
        assert (bus.data_out === m_dout) else begin
            errors++;
            $error("[TB] FAIL data_out observed=%h expected=%h", bus.data_out, m_dout);
        end
        checks++;
        assert (bus.full === exp_full) else begin
            errors++;
            $error("[TB] FAIL full observed=%b expected=%b", bus.full, exp_full);
        end
        checks++;
        assert (bus.empty === exp_empty) else begin
            errors++;
            $error("[TB] FAIL empty observed=%b expected=%b", bus.empty, exp_empty);
        end
`ifdef FIFO_ERR_FLAG_EN
        checks++;
        assert (bus.err === m_err) else begin
            errors++;
            $error("[TB] FAIL err observed=%b expected=%b", bus.err, m_err);
        end
`endif
    endtask

    // Directed packet check against fixed bytes, independent of the model
    task automatic checkByte(input logic [7:0] expected);
        checks++;
        assert (bus.data_out === expected) else begin
            errors++;
            $error("[TB] FAIL packet_byte observed=%h expected=%h", bus.data_out, expected);
        end
    endtask

    initial begin
        logic [7:0] pkt[5];
        logic       we;
        logic       re;
        logic       sr;
        m_dout = 8'h00;
        m_cnt  = 6'd0;
        m_err  = 1'b0;
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h5A;

        // Reset then idle reads on an empty FIFO
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        checkByte(8'h00);
        applyStimulus(0, 1, 0, 0, 0, 8'h00);

        // Packet pass-through: header with payload length 3, then payload and parity
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, (i == 0), pkt[i]);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 8'h00);
            checkByte(pkt[i]);
        end
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkByte(8'h00);

        // Fill, overflow push, then drain
        for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 0, 8'h00);

        // Full with simultaneous push+pop, then empty with simultaneous push+pop
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 8'(8'h80 + i));
        applyStimulus(0, 0, 1, 1, 0, 8'hEE);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 1, 0, 8'h77);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);

        // Stream 40 bytes through across the pointer wrap
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, (i > 2), 0, 8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 8'h00);

        // soft_reset mid-packet with a concurrent push
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, (i == 0), 8'(8'h14 + i));
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 0, 8'hCC);
        checkByte(8'h00);

        // Sticky err path: pop while empty, then normal traffic, then soft_reset
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 0, 8'h01);
        applyStimulus(0, 0, 0, 1, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 0, 8'h00);

        // Randomized traffic, alternating push-heavy and pop-heavy phases
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 60; i++) begin
                we = ($urandom_range(0, 9) < ((p % 2 == 0) ? 8 : 3));
                re = ($urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 8));
                sr = ($urandom_range(0, 79) == 0);
                applyStimulus(0, sr, we, re, ($urandom_range(0, 5) == 0), 8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
